hamming_frame_ctrl: RTL and testbench
=====================================

HAMMING_FRAME_CTRL -- requirements
Module: hamming_frame_ctrl

Interface
REQ-001 SHALL have parameter: CNT_W, 8, width of the saturating error counters.
REQ-002 SHALL have port: clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  in  1  reset; synchronous and active-high.
REQ-004 SHALL have port: datain  in  1  serial code bit, codeword position 0 first.
REQ-005 SHALL have port: din_valid  in  1  datain valid.
REQ-006 SHALL have port: din_ready  out  1  controller accepts a bit this cycle.
REQ-007 SHALL have port: dout  out  11  corrected data bits.
REQ-008 SHALL have port: dout_valid  out  1  dout, status and err_pos valid.
REQ-009 SHALL have port: dout_ready  in  1  consumer accepts the frame.
REQ-010 SHALL have port: status  out  2  result: 0 OK, 1 CORR, 2 DED.
REQ-011 SHALL have port: err_pos  out  4  corrected bit position; 0 unless status=CORR.
REQ-012 SHALL have port: corr_cnt  out  CNT_W  count of CORR frames, saturating.
REQ-013 SHALL have port: ded_cnt  out  CNT_W  count of DED frames, saturating.

Function
REQ-014 SHALL implement Hamming(16,11) SECDED: position 0 is overall parity; positions 1,2,4,8 are check bits; data bits are positions 3,5,6,7,9..15 in that order, mapped to dout[0]..dout[10].
REQ-015 SHALL accept a bit only on a cycle with din_valid=1 and din_ready=1; all other cycles leave frame state unchanged.
REQ-016 SHALL accumulate the syndrome as the XOR of the 4-bit indices of all accepted 1-bits, and the parity as the XOR of all accepted bits, with a 4-bit bit counter.
REQ-017 SHALL use the FSM states RECV, EVAL and OUT.
REQ-018 In RECV, SHALL hold din_ready=1; on acceptance of bit 15, the counter SHALL wrap to 0 and the next state SHALL be EVAL.
REQ-019 EVAL SHALL last exactly one cycle with din_ready=0, then go to OUT; dout_valid SHALL rise on the second edge after bit 15 is accepted.
REQ-020 SHALL classify the frame as follows: syndrome=0 and parity=0 gives OK; parity=1 gives CORR, err_pos=syndrome, and flips that position (syndrome 0 means the parity bit, so data is unchanged); syndrome!=0 and parity=0 gives DED, err_pos=0, and dout is the uncorrected data.
REQ-021 In OUT, SHALL hold dout_valid=1 and hold dout, status and err_pos stable until dout_ready=1, with din_ready=0.
REQ-022 On the OUT handshake, SHALL go to RECV with the syndrome and parity cleared, and din_ready SHALL be 1 in the next cycle.
REQ-023 SHALL increment corr_cnt or ded_cnt by one on the EVAL cycle of each CORR or DED frame respectively, and SHALL hold each counter at 2^CNT_W-1 once reached.
REQ-024 SHALL ignore din_valid while not in RECV, so that no bit is lost or double-counted.

Reset
REQ-025 SHALL, when rst=1 at a clock edge, set state=RECV, the counter, syndrome and parity to 0, dout=0, status=0, err_pos=0, dout_valid=0, corr_cnt=0 and ded_cnt=0; din_ready SHALL be 1 after the reset edge.
REQ-026 SHALL give rst priority over all activity, including in the middle of a frame or during OUT; any partial frame SHALL be discarded and no output produced.

Configuration
REQ-027 With HAMMING_DED_EN defined, SHALL behave as in REQ-020.
REQ-028 Without HAMMING_DED_EN, SHALL ignore parity: syndrome=0 gives OK, syndrome!=0 gives CORR with the bit at the syndrome position flipped; status=2 SHALL never occur; ded_cnt SHALL be tied to 0.

Structure
REQ-029 SHALL take from shared package hamming_pkg: BLK_LEN=16, DATA_W=11, POS_W=4, the status enum (ST_OK, ST_CORR, ST_DED) and the FSM state enum.
REQ-030 SHALL instantiate one sub-module, hamming_syndrome_acc (bit counter, syndrome and parity registers, clear/enable inputs), alongside the FSM and output stage.

Verification
REQ-031 SHALL cover: all-zero codeword, din_valid=1 throughout -> dout=0, status=0, err_pos=0, dout_valid asserted on the 2nd edge after bit 15.
REQ-032 SHALL cover: all-ones codeword -> status=0, dout=11'h7FF.
REQ-033 SHALL cover: all-zero codeword with bit 5 flipped -> status=1, err_pos=5, dout=0, corr_cnt=1.
REQ-034 SHALL cover: all-zero codeword with bits 3 and 5 flipped -> status=2 with HAMMING_DED_EN, dout=11'h003, ded_cnt=1; without the macro: status=1, err_pos=6.
REQ-035 SHALL cover: all-zero codeword with bit 0 flipped -> status=1, err_pos=0, dout=0.
REQ-036 SHALL cover: din_valid toggled randomly, dout_ready held low for 10 cycles, and rst pulsed after bit 7 -> outputs stable while stalled, no lost bits, partial frame discarded, next full frame decoded correctly.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared constants, enums and helpers for the Hamming(16,11) SECDED frame controller.
package hamming_pkg;

  localparam int BLK_LEN = 16;
  localparam int DATA_W  = 11;
  localparam int POS_W   = 4;

  typedef enum logic [1:0] {
    ST_OK   = 2'd0,
    ST_CORR = 2'd1,
    ST_DED  = 2'd2
  } status_e;

  typedef enum logic [1:0] {
    RECV = 2'd0,
    EVAL = 2'd1,
    OUT  = 2'd2
  } state_e;

  // Data lives at the non-power-of-two positions 3,5,6,7,9..15, lowest position first.
  function automatic logic [DATA_W-1:0] extract_data(input logic [BLK_LEN-1:0] cw);
    extract_data = {cw[15:9], cw[7:5], cw[3]};
  endfunction

  function automatic logic [BLK_LEN-1:0] pos_mask(input logic [POS_W-1:0] pos);
    pos_mask = BLK_LEN'(1) << pos;
  endfunction

endpackage

// File: rtl/hamming_syndrome_acc.sv
// Serial codeword accumulator: bit counter, captured codeword, running syndrome and overall parity.
module hamming_syndrome_acc
  import hamming_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic               bit_i,
  output logic [POS_W-1:0]   cnt_o,
  output logic [POS_W-1:0]   syndrome_o,
  output logic               parity_o,
  output logic [BLK_LEN-1:0] frame_o
);

  logic [POS_W-1:0]   cnt_q;
  logic [POS_W-1:0]   syn_q;
  logic               par_q;
  logic [BLK_LEN-1:0] frame_q;

  // The counter wraps naturally from 15 to 0, so the next frame starts at position 0.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q   <= '0;
      syn_q   <= '0;
      par_q   <= 1'b0;
      frame_q <= '0;
    end else if (en_i) begin
      frame_q[cnt_q] <= bit_i;
      if (bit_i) begin
        syn_q <= syn_q ^ cnt_q;
      end
      par_q <= par_q ^ bit_i;
      cnt_q <= cnt_q + POS_W'(1);
    end
  end

  assign cnt_o      = cnt_q;
  assign syndrome_o = syn_q;
  assign parity_o   = par_q;
  assign frame_o    = frame_q;

endmodule

// File: rtl/hamming_frame_ctrl.sv
// Hamming(16,11) frame controller: serial receive, one-cycle decode, held output with handshake.
// Define HAMMING_DED_EN to enable double-error detection via the overall parity bit.
module hamming_frame_ctrl
  import hamming_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              datain,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [1:0]        status,
  output logic [POS_W-1:0]  err_pos,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  ded_cnt
);

  state_e              state_q;
  logic                din_ready_q;
  logic                dout_valid_q;
  logic [DATA_W-1:0]   dout_q;
  status_e             status_q;
  logic [POS_W-1:0]    err_pos_q;
  logic [CNT_W-1:0]    corr_cnt_q;

  logic [POS_W-1:0]    cnt;
  logic [POS_W-1:0]    syndrome;
  logic                parity;
  logic [BLK_LEN-1:0]  frame;

  logic                accept;
  logic                handshake;
  logic                flip_d;
  logic [DATA_W-1:0]   dout_d;
  status_e             status_d;
  logic [POS_W-1:0]    err_pos_d;

  assign accept    = din_valid && din_ready_q && (state_q == RECV);
  assign handshake = (state_q == OUT) && dout_ready;

  hamming_syndrome_acc u_acc (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (handshake),
    .en_i       (accept),
    .bit_i      (datain),
    .cnt_o      (cnt),
    .syndrome_o (syndrome),
    .parity_o   (parity),
    .frame_o    (frame)
  );

  always_comb begin
    flip_d    = 1'b0;
    status_d  = ST_OK;
    err_pos_d = '0;
`ifdef HAMMING_DED_EN
    // An odd overall parity means a single error; syndrome 0 then points at the parity bit itself.
    if (parity) begin
      flip_d    = 1'b1;
      status_d  = ST_CORR;
      err_pos_d = syndrome;
    end else if (syndrome != '0) begin
      status_d  = ST_DED;
    end
`else
    if (syndrome != '0) begin
      flip_d    = 1'b1;
      status_d  = ST_CORR;
      err_pos_d = syndrome;
    end
`endif
    dout_d = extract_data(frame ^ (flip_d ? pos_mask(syndrome) : '0));
  end

`ifdef HAMMING_DED_EN
  logic [CNT_W-1:0] ded_cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RECV;
      din_ready_q  <= 1'b1;
      dout_valid_q <= 1'b0;
      dout_q       <= '0;
      status_q     <= ST_OK;
      err_pos_q    <= '0;
      corr_cnt_q   <= '0;
`ifdef HAMMING_DED_EN
      ded_cnt_q    <= '0;
`endif
    end else begin
      case (state_q)
        RECV: begin
          if (accept && (cnt == POS_W'(BLK_LEN - 1))) begin
            state_q     <= EVAL;
            din_ready_q <= 1'b0;
          end
        end
        EVAL: begin
          state_q      <= OUT;
          dout_valid_q <= 1'b1;
          dout_q       <= dout_d;
          status_q     <= status_d;
          err_pos_q    <= err_pos_d;
          if ((status_d == ST_CORR) && (corr_cnt_q != '1)) begin
            corr_cnt_q <= corr_cnt_q + CNT_W'(1);
          end
`ifdef HAMMING_DED_EN
          if ((status_d == ST_DED) && (ded_cnt_q != '1)) begin
            ded_cnt_q <= ded_cnt_q + CNT_W'(1);
          end
`endif
        end
        OUT: begin
          if (dout_ready) begin
            state_q      <= RECV;
            din_ready_q  <= 1'b1;
            dout_valid_q <= 1'b0;
          end
        end
        default: state_q <= RECV;
      endcase
    end
  end

  assign din_ready  = din_ready_q;
  assign dout_valid = dout_valid_q;
  assign dout       = dout_q;
  assign status     = status_q;
  assign err_pos    = err_pos_q;
  assign corr_cnt   = corr_cnt_q;
`ifdef HAMMING_DED_EN
  assign ded_cnt    = ded_cnt_q;
`else
  assign ded_cnt    = '0;
`endif

endmodule

// File: tb/tb_hamming_frame_ctrl.sv
// Directed self-checking bench for hamming_frame_ctrl; expectations follow HAMMING_DED_EN when defined.
module tb_hamming_frame_ctrl;

  localparam int CNT_W = 8;
`ifdef HAMMING_DED_EN
  localparam bit DED = 1'b1;
`else
  localparam bit DED = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             datain;
  logic             din_valid;
  logic             din_ready;
  logic [10:0]      dout;
  logic             dout_valid;
  logic             dout_ready;
  logic [1:0]       status;
  logic [3:0]       err_pos;
  logic [CNT_W-1:0] corr_cnt;
  logic [CNT_W-1:0] ded_cnt;

  int vectors     = 0;
  int miscompares = 0;
  int expCorr     = 0;
  int expDed      = 0;

  always #5 clk = ~clk;

  hamming_frame_ctrl #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .datain     (datain),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .status     (status),
    .err_pos    (err_pos),
    .corr_cnt   (corr_cnt),
    .ded_cnt    (ded_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sends the first nbits of cw, optionally with random idle cycles between bits.
  task automatic applyStimulus(input logic [15:0] cw, input int nbits, input bit randGaps);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      if (randGaps) begin
        for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) begin
          din_valid = 1'b0;
          datain    = ~cw[i];
          @(negedge clk);
        end
      end
      din_valid = 1'b1;
      datain    = cw[i];
      @(posedge clk);
    end
    #1;
    datain = 1'b1;
    if (nbits != 16) din_valid = 1'b0;
  endtask

  task automatic waitValid(input string tag);
    int c = 0;
    while (dout_valid !== 1'b1 && c < 40) begin
      @(posedge clk);
      #1;
      c++;
    end
    check({tag, "_valid"}, 32'(dout_valid), 32'd1);
  endtask

  task automatic checkOutput(input string tag, input logic [10:0] expDout,
                             input logic [1:0] expStatus, input logic [3:0] expPos);
    waitValid(tag);
    check({tag, "_dout"},     32'(dout),     32'(expDout));
    check({tag, "_status"},   32'(status),   32'(expStatus));
    check({tag, "_err_pos"},  32'(err_pos),  32'(expPos));
    check({tag, "_corr_cnt"}, 32'(corr_cnt), 32'(expCorr));
    check({tag, "_ded_cnt"},  32'(ded_cnt),  32'(expDed));
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    @(posedge clk);
    #1;
    dout_ready = 1'b0;
    check({tag, "_hs_din_ready"},  32'(din_ready),  32'd1);
    check({tag, "_hs_dout_valid"}, 32'(dout_valid), 32'd0);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst       = 1'b1;
    din_valid = 1'b0;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    expCorr = 0;
    expDed  = 0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    datain     = 1'b0;
    din_valid  = 1'b0;
    dout_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_din_ready",  32'(din_ready),  32'd1);
    check("rst_dout_valid", 32'(dout_valid), 32'd0);
    check("rst_dout",       32'(dout),       32'd0);
    check("rst_status",     32'(status),     32'd0);
    check("rst_err_pos",    32'(err_pos),    32'd0);
    check("rst_corr_cnt",   32'(corr_cnt),   32'd0);
    check("rst_ded_cnt",    32'(ded_cnt),    32'd0);

    // All-zero codeword, din_valid held high; dout_valid rises on the EVAL edge.
    applyStimulus(16'h0000, 16, 1'b0);
    check("zero_eval_valid", 32'(dout_valid), 32'd0);
    check("zero_eval_ready", 32'(din_ready),  32'd0);
    @(posedge clk);
    #1;
    check("zero_out_valid",  32'(dout_valid), 32'd1);
    checkOutput("zero", 11'h000, 2'd0, 4'd0);
    handshake("zero");

    applyStimulus(16'hFFFF, 16, 1'b0);
    checkOutput("ones", 11'h7FF, 2'd0, 4'd0);
    handshake("ones");

    // Bits 0..3 set: data bit 3 with check bits 1,2 and even overall parity.
    applyStimulus(16'h000F, 16, 1'b0);
    checkOutput("d0", 11'h001, 2'd0, 4'd0);
    handshake("d0");

    applyStimulus(16'h0020, 16, 1'b0);
    expCorr++;
    checkOutput("err5", 11'h000, 2'd1, 4'd5);
    handshake("err5");

    applyStimulus(16'h0028, 16, 1'b0);
    if (DED) begin
      expDed++;
      checkOutput("err35", 11'h003, 2'd2, 4'd0);
    end else begin
      expCorr++;
      checkOutput("err35", 11'h007, 2'd1, 4'd6);
    end
    handshake("err35");

    applyStimulus(16'h0001, 16, 1'b0);
    if (DED) begin
      expCorr++;
      checkOutput("err0", 11'h000, 2'd1, 4'd0);
    end else begin
      checkOutput("err0", 11'h000, 2'd0, 4'd0);
    end
    handshake("err0");

    // Random din_valid gaps, then a 10-cycle consumer stall with din_valid still toggling.
    applyStimulus(16'h020F, 16, 1'b1);
    expCorr++;
    checkOutput("stall", 11'h001, 2'd1, 4'd9);
    for (int s = 0; s < 10; s++) begin
      @(negedge clk);
      din_valid = 1'($urandom_range(0, 1));
      datain    = 1'($urandom_range(0, 1));
      check("stall_valid",   32'(dout_valid), 32'd1);
      check("stall_dout",    32'(dout),       32'h001);
      check("stall_status",  32'(status),     32'd1);
      check("stall_err_pos", 32'(err_pos),    32'd9);
    end
    handshake("stall");

    // Reset after bit 7 discards the partial frame.
    applyStimulus(16'hFFFF, 8, 1'b1);
    pulseReset();
    check("midrst_din_ready",  32'(din_ready),  32'd1);
    check("midrst_dout_valid", 32'(dout_valid), 32'd0);
    check("midrst_corr_cnt",   32'(corr_cnt),   32'd0);
    check("midrst_ded_cnt",    32'(ded_cnt),    32'd0);
    applyStimulus(16'h100F, 16, 1'b1);
    expCorr++;
    checkOutput("after_rst", 11'h001, 2'd1, 4'd12);
    handshake("after_rst");

    // Reset while a frame is being presented.
    applyStimulus(16'h0008, 16, 1'b0);
    waitValid("outrst");
    pulseReset();
    check("outrst_dout_valid", 32'(dout_valid), 32'd0);
    check("outrst_dout",       32'(dout),       32'd0);
    check("outrst_status",     32'(status),     32'd0);
    check("outrst_err_pos",    32'(err_pos),    32'd0);
    check("outrst_corr_cnt",   32'(corr_cnt),   32'd0);
    check("outrst_din_ready",  32'(din_ready),  32'd1);

    // Drive the correction counter past its maximum.
    for (int f = 0; f < 260; f++) begin
      applyStimulus(16'h0020, 16, 1'b0);
      waitValid("sat");
      handshake("sat");
    end
    check("sat_corr_cnt", 32'(corr_cnt), 32'd255);
    check("sat_ded_cnt",  32'(ded_cnt),  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
